px_stream_fifo: RTL and testbench

Elastic pixel buffer between the grayscale/Sobel pipeline output and the SPI return path. Absorbs bursts of single-cycle `px_rdy` pixel strobes from the processing pipeline. Replays the pixels, in order, as single-cycle strobes whenever the SPI side signals it can take one. Reports occupancy and overflow so firmware can detect dropped pixels.

---
 rtl/px_stream_fifo_pkg.sv | 5 +
 rtl/px_fifo_mem.sv | 27 ++
 rtl/px_stream_fifo.sv | 114 +++++++++++
 tb/tb_px_stream_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/px_stream_fifo_pkg.sv
// Shared sizing constants for the pixel return-path FIFO.
package px_stream_fifo_pkg;
    localparam int MAX_PIXEL_BITS = 24;
    localparam int PX_FIFO_DEPTH  = 8;
endpackage

// File: rtl/px_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module px_fifo_mem
    import px_stream_fifo_pkg::*;
#(
    parameter int WIDTH = MAX_PIXEL_BITS,
    parameter int DEPTH = PX_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately never reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/px_stream_fifo.sv
// Elastic pixel buffer between the Sobel pipeline and the SPI return path.
// Optional macro PX_FIFO_OVF_STICKY_EN makes overflow_o sticky until flush/reset.
module px_stream_fifo
    import px_stream_fifo_pkg::*;
#(
    parameter int WIDTH = MAX_PIXEL_BITS,
    parameter int DEPTH = PX_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     flush_i,
    input  logic                     px_rdy_i,
    input  logic [WIDTH-1:0]         in_pixel_i,
    input  logic                     out_ready_i,
    output logic                     px_rdy_o,
    output logic [WIDTH-1:0]         out_pixel_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] pix_q, pix_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rd_data;
    logic             full, empty, push, pop, drop, mem_we;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop on a full buffer frees the slot the same-cycle push lands in.
    assign pop    = out_ready_i & ~empty;
    assign push   = px_rdy_i & (~full | pop);
    assign drop   = px_rdy_i & full & ~pop;
    assign mem_we = push & ~flush_i;

    px_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (in_pixel_i),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        vld_d   = 1'b0;
        pix_d   = pix_q;
        ovf_d   = 1'b0;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
                pix_d  = rd_data;
                vld_d  = 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
`ifdef PX_FIFO_OVF_STICKY_EN
            ovf_d = ovf_q | drop;
`else
            ovf_d = drop;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
            pix_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            pix_q   <= pix_d;
            ovf_q   <= ovf_d;
        end
    end

    assign px_rdy_o    = vld_q;
    assign out_pixel_o = pix_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_px_stream_fifo.sv
// Directed bench for px_stream_fifo; honours PX_FIFO_OVF_STICKY_EN when defined.
module tb_px_stream_fifo;

    localparam int WIDTH = 24;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             nreset;
    logic             flush;
    logic             px_rdy_in;
    logic [WIDTH-1:0] in_pixel;
    logic             out_ready;
    logic             px_rdy_out;
    logic [WIDTH-1:0] out_pixel;
    logic [3:0]       count;
    logic             full, empty, overflow;

    int vectors = 0;
    int miscompares = 0;
`ifdef PX_FIFO_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    px_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .flush_i     (flush),
        .px_rdy_i    (px_rdy_in),
        .in_pixel_i  (in_pixel),
        .out_ready_i (out_ready),
        .px_rdy_o    (px_rdy_out),
        .out_pixel_o (out_pixel),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [WIDTH-1:0] base, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            px_rdy_in = 1'b1;
            in_pixel  = base + WIDTH'(i);
            step();
        end
        px_rdy_in = 1'b0;
    endtask

    initial begin
        nreset = 1'b0; flush = 1'b0; px_rdy_in = 1'b0; in_pixel = '0; out_ready = 1'b0;
        step(); step();
        nreset = 1'b1;
        step();
        // 1. reset values and minimum latency
        check("rst_vld", px_rdy_out, 0);
        check("rst_pix", out_pixel, 0);
        check("rst_cnt", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        px_rdy_in = 1'b1; in_pixel = 24'hA5A5A5; out_ready = 1'b1;
        step();
        px_rdy_in = 1'b0;
        check("lat_t1_vld", px_rdy_out, 0);
        check("lat_t1_cnt", count, 1);
        step();
        check("lat_t2_vld", px_rdy_out, 1);
        check("lat_t2_pix", out_pixel, 24'hA5A5A5);
        check("lat_t2_cnt", count, 0);
        step();
        check("lat_t3_vld", px_rdy_out, 0);

        // 2/3. fill, overflow, drain
        push_seq(24'h000001, 8);
        check("fill_full", full, 1);
        check("fill_cnt", count, 8);
        check("fill_empty", empty, 0);
        px_rdy_in = 1'b1; in_pixel = 24'hFFFFFF;
        step();
        px_rdy_in = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_cnt", count, 8);
        step();
        check("ovf_next", overflow, STICKY);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("drain_vld", px_rdy_out, 1);
            check("drain_pix", out_pixel, i);
        end
        step();
        check("drain_end_vld", px_rdy_out, 0);
        check("drain_end_empty", empty, 1);
        check("drain_end_pix", out_pixel, 8);
        check("drain_end_ovf", overflow, STICKY);
        out_ready = 1'b0;

        // 4a. push+pop on a full buffer
        push_seq(24'h000011, 8);
        px_rdy_in = 1'b1; in_pixel = 24'h000099; out_ready = 1'b1;
        step();
        px_rdy_in = 1'b0;
        check("fpp_cnt", count, 8);
        check("fpp_ovf", overflow, STICKY);
        check("fpp_vld", px_rdy_out, 1);
        check("fpp_pix", out_pixel, 24'h000011);
        for (int i = 2; i <= 8; i++) begin
            step();
            check("fpp_drain_pix", out_pixel, 24'h000010 + i);
        end
        step();
        check("fpp_new_vld", px_rdy_out, 1);
        check("fpp_new_pix", out_pixel, 24'h000099);
        step();
        check("fpp_end_vld", px_rdy_out, 0);
        check("fpp_end_empty", empty, 1);

        // 4b. push+pop on an empty buffer: no fall-through
        px_rdy_in = 1'b1; in_pixel = 24'h000042; out_ready = 1'b1;
        step();
        px_rdy_in = 1'b0;
        check("epp_vld", px_rdy_out, 0);
        check("epp_cnt", count, 1);
        step();
        check("epp_vld2", px_rdy_out, 1);
        check("epp_pix2", out_pixel, 24'h000042);
        check("epp_cnt2", count, 0);
        out_ready = 1'b0;

        // 5. flush beats push and pop
        push_seq(24'h000051, 5);
        check("fl_pre_cnt", count, 5);
        flush = 1'b1; px_rdy_in = 1'b1; in_pixel = 24'h000077; out_ready = 1'b1;
        step();
        flush = 1'b0; px_rdy_in = 1'b0;
        check("fl_cnt", count, 0);
        check("fl_vld", px_rdy_out, 0);
        check("fl_ovf", overflow, 0);
        check("fl_pix", out_pixel, 24'h000042);
        check("fl_empty", empty, 1);
        step();
        check("fl_after_vld", px_rdy_out, 0);
        check("fl_after_cnt", count, 0);
        out_ready = 1'b0;

        // 6. reset during a drain
        push_seq(24'h000061, 5);
        out_ready = 1'b1;
        step();
        check("rm_pix1", out_pixel, 24'h000061);
        step();
        check("rm_pix2", out_pixel, 24'h000062);
        check("rm_cnt", count, 3);
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        check("rm_vld", px_rdy_out, 0);
        check("rm_pix", out_pixel, 0);
        check("rm_cnt0", count, 0);
        check("rm_empty", empty, 1);
        check("rm_full", full, 0);
        check("rm_ovf", overflow, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rm_quiet_vld", px_rdy_out, 0);
            check("rm_quiet_cnt", count, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
